e603_sram_req_ctrl: RTL and testbench

E603_SRAM_REQ_CTRL -- requirements
Module: e603_sram_req_ctrl

---
 rtl/e603_sram_ctrl_pkg.sv | 26 ++
 rtl/e603_sram_rsp_fifo.sv | 62 ++++++
 rtl/e603_sram_req_ctrl.sv | 155 +++++++++++++++
 tb/tb_e603_sram_req_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/e603_sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : e603_sram_ctrl_pkg
// Brief    : Shared power-state encoding and credit depth for the SRAM
//            request controller.
// Revision : 1.0 - initial release
// ============================================================================
package e603_sram_ctrl_pkg;

    typedef enum logic [1:0] {
        PWR_ACTIVE = 2'd0,
        PWR_SLEEP  = 2'd1,
        PWR_WAKE   = 2'd2
    } pwr_state_e;

    localparam int unsigned CREDIT_DEPTH = 3;
    localparam int unsigned CREDIT_W     = 2;

    typedef struct packed {
        logic vld;
        logic read;
        logic err;
    } inflight_t;

endpackage
`default_nettype wire

// File: rtl/e603_sram_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : e603_sram_rsp_fifo
// Brief    : Small circular response FIFO; head is visible combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module e603_sram_rsp_fifo
    import e603_sram_ctrl_pkg::*;
#(
    parameter int unsigned W     = 33,
    parameter int unsigned DEPTH = CREDIT_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [W-1:0]                 data_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 head_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = $clog2(DEPTH + 1);

    logic [W-1:0]    mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CNTW-1:0] count_q;
    logic [PW-1:0]   wr_ptr_nxt;
    logic [PW-1:0]   rd_ptr_nxt;

    assign wr_ptr_nxt = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    assign rd_ptr_nxt = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_nxt;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_nxt;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/e603_sram_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : e603_sram_req_ctrl
// Brief    : Credit-based SRAM request/response controller with idle
//            light-sleep power management.
// Revision : 1.0 - initial release
// ============================================================================
module e603_sram_req_ctrl
    import e603_sram_ctrl_pkg::*;
#(
    parameter int unsigned DP       = 512,
    parameter int unsigned DW       = 32,
    parameter int unsigned MW       = 4,
    parameter int unsigned AW       = 32,
    parameter int unsigned IDLE_CYC = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_read,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [MW-1:0] cmd_wmask,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [MW-1:0] ram_wem,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          ram_ls,
    output logic          ram_ds,
    output logic          ram_sd
);

    localparam int unsigned SHIFT = $clog2(MW);
    localparam int unsigned CW    = (IDLE_CYC > 0) ? $clog2(IDLE_CYC + 1) : 1;
    localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_CYC);

    pwr_state_e        state_q, state_d;
    logic [CW-1:0]     idle_cnt_q, idle_cnt_d;
    inflight_t         inflight_q, inflight_d;

    logic [AW-1:0]     word_addr;
    logic              in_range;
    logic              cmd_fire;
    logic [CREDIT_W-1:0] credit;
    logic [CREDIT_W-1:0] fifo_count;
    logic              fifo_empty;
    logic [DW:0]       fifo_head;
    logic [DW:0]       fifo_din;
    logic              rsp_pop;

    assign word_addr = cmd_addr >> SHIFT;
    assign in_range  = (word_addr < AW'(DP));

    // Credits cover both buffered responses and the one still waiting on ram_dout.
    assign credit    = fifo_count + CREDIT_W'(inflight_q.vld);
    assign cmd_ready = rst_n && (state_q == PWR_ACTIVE) && (credit != CREDIT_W'(CREDIT_DEPTH));
    assign cmd_fire  = cmd_valid && cmd_ready;

    assign ram_cs   = cmd_fire && in_range;
    assign ram_we   = ram_cs && !cmd_read;
    assign ram_wem  = cmd_wmask;
    assign ram_addr = word_addr;
    assign ram_din  = cmd_wdata;
    assign ram_ls   = rst_n && (state_q == PWR_SLEEP);
    assign ram_ds   = 1'b0;
    assign ram_sd   = 1'b0;

    always_comb begin
        inflight_d      = '0;
        inflight_d.vld  = cmd_fire;
        inflight_d.read = cmd_read;
        inflight_d.err  = !in_range;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign fifo_din = {inflight_q.err,
                       (inflight_q.read && !inflight_q.err) ? ram_dout : {DW{1'b0}}};
    assign rsp_pop  = rsp_valid && rsp_ready;

    e603_sram_rsp_fifo #(
        .W     (DW + 1),
        .DEPTH (CREDIT_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (inflight_q.vld),
        .data_i  (fifo_din),
        .pop_i   (rsp_pop),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign rsp_valid = rst_n && !fifo_empty;
    assign rsp_rdata = rsp_valid ? fifo_head[DW-1:0] : '0;
    assign rsp_err   = rsp_valid && fifo_head[DW];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= PWR_ACTIVE;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        case (state_q)
            PWR_ACTIVE: begin
                if (!cmd_fire && (credit == '0)) begin
                    if (idle_cnt_q != IDLE_MAX) begin
                        idle_cnt_d = idle_cnt_q + CW'(1);
                    end
                    if ((IDLE_CYC != 0) && (idle_cnt_d == IDLE_MAX)) begin
                        state_d = PWR_SLEEP;
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end
            PWR_SLEEP: begin
                if (cmd_valid) begin
                    state_d = PWR_WAKE;
                end
            end
            PWR_WAKE: begin
                state_d    = PWR_ACTIVE;
                idle_cnt_d = '0;
            end
            default: begin
                state_d    = PWR_ACTIVE;
                idle_cnt_d = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_e603_sram_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_e603_sram_req_ctrl
// Brief    : Directed self-checking bench for e603_sram_req_ctrl with a
//            behavioural one-cycle-latency RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_e603_sram_req_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_read;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        ram_cs, ram_we, ram_ls, ram_ds, ram_sd;
    logic [3:0]  ram_wem;
    logic [31:0] ram_addr, ram_din;
    logic [31:0] ram_dout;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:511];

    always #5 clk = ~clk;

    e603_sram_req_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_read  (cmd_read),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wmask (cmd_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_wem   (ram_wem),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .ram_ls    (ram_ls),
        .ram_ds    (ram_ds),
        .ram_sd    (ram_sd)
    );

    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (ram_wem[i]) mem[ram_addr[8:0]][8*i +: 8] <= ram_din[8*i +: 8];
                end
            end else begin
                ram_dout <= mem[ram_addr[8:0]];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one command from a negedge, waits for acceptance, returns at the next negedge.
    task automatic send(input logic rd, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] m, output logic cs, output logic we,
                        output logic [31:0] ra);
        int b;
        b = 0;
        cmd_valid = 1'b1; cmd_read = rd; cmd_addr = addr; cmd_wdata = wd; cmd_wmask = m;
        #1;
        while (!cmd_ready && b < 20) begin
            @(negedge clk); #1; b++;
        end
        chk("send_accept_timeout", 64'(b < 20), 64'd1);
        cs = ram_cs; we = ram_we; ra = ram_addr;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [31:0] exp_d, input logic exp_e);
        int b;
        b = 0;
        #1;
        while (!rsp_valid && b < 20) begin
            @(negedge clk); #1; b++;
        end
        chk({tag, "_timeout"}, 64'(b < 20), 64'd1);
        chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(exp_d));
        chk({tag, "_err"}, 64'(rsp_err), 64'(exp_e));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic        cs, we, took, seen;
        logic [31:0] ra;
        logic [31:0] bp_val [5];
        int          sent, got;

        bp_val[0] = 32'h0BAD_F00D; bp_val[1] = 32'h1234_5678; bp_val[2] = 32'hCAFE_BABE;
        bp_val[3] = 32'h0000_0001; bp_val[4] = 32'hFFFF_FFFE;

        rst_n = 1'b0; cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = 32'h0;
        cmd_wdata = 32'h0; cmd_wmask = 4'h0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_ram_cs", 64'(ram_cs), 64'd0);
        chk("rst_ram_we", 64'(ram_we), 64'd0);
        chk("rst_ram_ls", 64'(ram_ls), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        @(negedge clk);
        cmd_valid = 1'b0; rst_n = 1'b1;
        #1;
        chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("ram_ds_sd", 64'({ram_ds, ram_sd}), 64'd0);
        @(negedge clk);

        // Full write then read back with latency check
        send(1'b0, 32'h10, 32'hDEAD_BEEF, 4'hF, cs, we, ra);
        chk("wr_cs", 64'(cs), 64'd1);
        chk("wr_we", 64'(we), 64'd1);
        chk("wr_addr", 64'(ra), 64'h4);
        recv("wr_rsp", 32'h0, 1'b0);

        send(1'b1, 32'h10, 32'h0, 4'h0, cs, we, ra);
        chk("rd_we", 64'(we), 64'd0);
        #1;
        chk("rd_valid_T1", 64'(rsp_valid), 64'd0);
        @(negedge clk); #1;
        chk("rd_valid_T2", 64'(rsp_valid), 64'd1);
        recv("rd_rsp", 32'hDEAD_BEEF, 1'b0);

        // Masked write of the low half
        send(1'b0, 32'h10, 32'h0000_FFFF, 4'h3, cs, we, ra);
        recv("mwr_rsp", 32'h0, 1'b0);
        send(1'b1, 32'h10, 32'h0, 4'h0, cs, we, ra);
        recv("mrd_rsp", 32'hDEAD_FFFF, 1'b0);

        for (int k = 0; k < 5; k++) begin
            send(1'b0, 32'h20 + 32'(4 * k), bp_val[k], 4'hF, cs, we, ra);
            recv("fill_rsp", 32'h0, 1'b0);
        end

        // Backpressure: only three credits
        sent = 0; took = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (took) sent++;
            cmd_valid = (sent < 5); cmd_read = 1'b1; cmd_addr = 32'h20 + 32'(4 * sent);
            #1;
            took = cmd_valid && cmd_ready;
        end
        chk("bp_accepted", 64'(sent), 64'd3);
        chk("bp_ready_low", 64'(cmd_ready), 64'd0);
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(negedge clk);
            if (took) sent++;
            cmd_valid = (sent < 5); cmd_addr = 32'h20 + 32'(4 * sent);
            rsp_ready = 1'b1;
            #1;
            took = cmd_valid && cmd_ready;
            if (rsp_valid) begin
                chk("bp_rdata", 64'(rsp_rdata), 64'(bp_val[got]));
                got++;
            end
        end
        chk("bp_count", 64'(got), 64'd5);
        @(negedge clk);
        cmd_valid = 1'b0; rsp_ready = 1'b0;

        // Out-of-range read
        send(1'b1, 32'd2048, 32'h0, 4'h0, cs, we, ra);
        chk("oor_cs", 64'(cs), 64'd0);
        recv("oor_rsp", 32'h0, 1'b1);

        // Idle into light sleep, then wake
        repeat (14) @(negedge clk);
        #1;
        chk("idle_not_yet_ls", 64'(ram_ls), 64'd0);
        got = 0;
        while (!ram_ls && got < 10) begin
            @(negedge clk); #1; got++;
        end
        chk("sleep_ls", 64'(ram_ls), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h10;
        #1;
        chk("sleep_ready", 64'(cmd_ready), 64'd0);
        chk("sleep_cs", 64'(ram_cs), 64'd0);
        @(negedge clk); #1;
        chk("wake_ls", 64'(ram_ls), 64'd0);
        chk("wake_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk); #1;
        chk("wake_accept_ready", 64'(cmd_ready), 64'd1);
        chk("wake_accept_cs", 64'(ram_cs), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        recv("wake_rd", 32'hDEAD_FFFF, 1'b0);

        // Reset one cycle after a read accept
        send(1'b1, 32'h10, 32'h0, 4'h0, cs, we, ra);
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_ready", 64'(cmd_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 64'(cmd_ready), 64'd1);
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            seen = seen | rsp_valid;
        end
        chk("post_rst_no_rsp", 64'(seen), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
